am_fm_demodulate: RTL and testbench



---
 rtl/am_fm_demodulate_pkg.sv | 19 +
 rtl/am_fm_demodulate_if.sv | 25 ++
 rtl/am_fm_demodulate_period_meter.sv | 88 ++++++++
 rtl/am_fm_demodulate.sv | 139 +++++++++++++
 tb/tb_am_fm_demodulate.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/am_fm_demodulate_pkg.sv
// Shared types and helpers for the AM/FM demodulator.
package demod_pkg;

    // Zero-crossing detector states
    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } fm_state_e;

    localparam logic MODE_AM = 1'b0;
    localparam logic MODE_FM = 1'b1;

    // Offset-binary midscale for a sample of the given width
    function automatic int unsigned midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/am_fm_demodulate_if.sv
// Sample/control bundle between the capture stage and the demodulator.
interface am_fm_demodulate_if #(
    parameter int unsigned INPUT_WIDTH  = 12,
    parameter int unsigned OUTPUT_WIDTH = 12,
    parameter int unsigned CNT_WIDTH    = 16
);
    logic                    Sel;
    logic                    sample_en;
    logic [INPUT_WIDTH-1:0]  wave_in;
    logic [CNT_WIDTH-1:0]    center_period;
    logic [3:0]              fm_gain_shift;
    logic [OUTPUT_WIDTH-1:0] wave_out;
    logic                    wave_valid;
    logic                    carrier_lost;

    modport master (
        output Sel, sample_en, wave_in, center_period, fm_gain_shift,
        input  wave_out, wave_valid, carrier_lost
    );

    modport slave (
        input  Sel, sample_en, wave_in, center_period, fm_gain_shift,
        output wave_out, wave_valid, carrier_lost
    );
endinterface

// File: rtl/am_fm_demodulate_period_meter.sv
// Hysteresis zero-crossing FSM with a saturating period counter and timeout.
module demod_period_meter
    import demod_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = 12,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned HYST        = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   sample_en_i,
    input  logic [INPUT_WIDTH-1:0] wave_in_i,
    input  logic                   clear_i,
    output logic [CNT_WIDTH-1:0]   period_o,
    output logic                   period_valid_o,
    output logic                   timeout_o
);

    localparam int MID    = int'(midscale(INPUT_WIDTH));
    localparam int LO_RAW = MID - int'(HYST);
    localparam int HI_RAW = MID + int'(HYST);
    localparam int TOP    = (1 << INPUT_WIDTH) - 1;
    localparam logic [INPUT_WIDTH-1:0] LO_THR = (LO_RAW < 0)   ? '0 : INPUT_WIDTH'(LO_RAW);
    localparam logic [INPUT_WIDTH-1:0] HI_THR = (HI_RAW > TOP) ? '1 : INPUT_WIDTH'(HI_RAW);
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX = '1;

    fm_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 armed_q, armed_d;
    logic                 below, above, saturated;

    assign below    = wave_in_i < LO_THR;
    assign above    = wave_in_i >= HI_THR;
    assign period_o = cnt_q;

    // Next-state, counter and event decode; the counter value stored at a
    // crossing is 1 so the value seen at the next crossing is the full period.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        armed_d        = armed_q;
        period_valid_o = 1'b0;
        timeout_o      = 1'b0;
        saturated      = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            armed_d = 1'b0;
        end else if (sample_en_i) begin
            case (state_q)
                IDLE: begin
                    if (below) state_d = LOW;
                end
                LOW, HIGH: begin
                    saturated = (cnt_q == CNT_MAX);
                    timeout_o = saturated;
                    cnt_d     = saturated ? cnt_q : cnt_q + CNT_WIDTH'(1);
                    if (state_q == HIGH && below) state_d = LOW;
                    if (state_q == LOW && above) begin
                        state_d        = HIGH;
                        cnt_d          = CNT_WIDTH'(1);
                        armed_d        = 1'b1;
                        period_valid_o = armed_q;
                    end else if (saturated) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        armed_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/am_fm_demodulate.sv
// AM envelope / FM period-to-deviation demodulator, offset-binary in and out.
module am_fm_demodulate
    import demod_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = 12,
    parameter int unsigned OUTPUT_WIDTH = 12,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned AVG_SHIFT    = 4,
    parameter int unsigned HYST         = 64
) (
    input  logic              clk_in,
    input  logic              RST,
    am_fm_demodulate_if.slave bus
);

    localparam int unsigned R_W   = INPUT_WIDTH - 1;
    localparam int unsigned ACC_W = R_W + AVG_SHIFT;
    localparam int unsigned DEV_W = CNT_WIDTH + 17;
    localparam logic [INPUT_WIDTH-1:0]  IN_MID   = INPUT_WIDTH'(midscale(INPUT_WIDTH));
    localparam logic [OUTPUT_WIDTH-1:0] OUT_MID  = OUTPUT_WIDTH'(midscale(OUTPUT_WIDTH));
    localparam logic signed [DEV_W-1:0] DEV_MID  = DEV_W'(midscale(OUTPUT_WIDTH));
    localparam logic signed [DEV_W-1:0] DEV_MAX  = DEV_W'((64'd1 << OUTPUT_WIDTH) - 64'd1);
    localparam logic [AVG_SHIFT:0]      WIN_LAST = (AVG_SHIFT + 1)'((64'd1 << AVG_SHIFT) - 64'd1);

    logic                     sel_q;
    logic [ACC_W-1:0]         acc_q, acc_d, acc_sum;
    logic [AVG_SHIFT:0]       win_cnt_q, win_cnt_d;
    logic [OUTPUT_WIDTH-1:0]  wave_out_q, wave_out_d;
    logic                     wave_valid_q, wave_valid_d;
    logic                     lost_q, lost_d;
    logic                     mode_change, meter_clear;
    logic [INPUT_WIDTH-1:0]   mag, envelope;
    logic [R_W-1:0]           rect;
    logic [OUTPUT_WIDTH-1:0]  am_out, fm_out;
    logic [CNT_WIDTH-1:0]     period;
    logic                     period_valid, timeout;
    logic signed [DEV_W-1:0]  dev, fm_sum;

    assign mode_change = (bus.Sel != sel_q);
    assign meter_clear = mode_change || (bus.Sel == MODE_AM);

    demod_period_meter #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH),
        .HYST        (HYST)
    ) u_meter (
        .clk_i          (clk_in),
        .rst_ni         (RST),
        .sample_en_i    (bus.sample_en),
        .wave_in_i      (bus.wave_in),
        .clear_i        (meter_clear),
        .period_o       (period),
        .period_valid_o (period_valid),
        .timeout_o      (timeout)
    );

    // Rectify and window-average; a full-scale negative sample (offset 2^(W-1))
    // saturates to the largest W-1 bit magnitude so the accumulator cannot overflow.
    always_comb begin
        mag      = (bus.wave_in >= IN_MID) ? bus.wave_in - IN_MID : IN_MID - bus.wave_in;
        rect     = mag[INPUT_WIDTH-1] ? '1 : mag[R_W-1:0];
        acc_sum  = acc_q + ACC_W'(rect);
        envelope = {acc_sum[ACC_W-1:AVG_SHIFT], 1'b0};
    end

    if (OUTPUT_WIDTH <= INPUT_WIDTH) begin : g_trunc
        assign am_out = envelope[INPUT_WIDTH-1 -: OUTPUT_WIDTH];
    end else begin : g_pad
        assign am_out = {envelope, {(OUTPUT_WIDTH - INPUT_WIDTH){1'b0}}};
    end

    // Period error scaled to a deviation around midscale, clamped to output range
    always_comb begin
        dev    = ($signed({17'b0, bus.center_period}) - $signed({17'b0, period})) <<< bus.fm_gain_shift;
        fm_sum = dev + DEV_MID;
        if (fm_sum < 0)             fm_out = '0;
        else if (fm_sum > DEV_MAX)  fm_out = '1;
        else                        fm_out = fm_sum[OUTPUT_WIDTH-1:0];
    end

    // Output and AM window control; a mode change overrides any completion
    always_comb begin
        acc_d        = acc_q;
        win_cnt_d    = win_cnt_q;
        wave_out_d   = wave_out_q;
        wave_valid_d = 1'b0;
        lost_d       = lost_q;
        if (mode_change) begin
            acc_d     = '0;
            win_cnt_d = '0;
            lost_d    = 1'b0;
        end else if (bus.sample_en) begin
            if (bus.Sel == MODE_AM) begin
                lost_d = 1'b0;
                if (win_cnt_q == WIN_LAST) begin
                    acc_d        = '0;
                    win_cnt_d    = '0;
                    wave_out_d   = am_out;
                    wave_valid_d = 1'b1;
                end else begin
                    acc_d     = acc_sum;
                    win_cnt_d = win_cnt_q + (AVG_SHIFT + 1)'(1);
                end
            end else if (period_valid) begin
                wave_out_d   = fm_out;
                wave_valid_d = 1'b1;
                lost_d       = timeout;
            end else if (timeout) begin
                wave_out_d   = OUT_MID;
                wave_valid_d = 1'b1;
                lost_d       = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_in) begin
        if (!RST) begin
            sel_q        <= MODE_AM;
            acc_q        <= '0;
            win_cnt_q    <= '0;
            wave_out_q   <= OUT_MID;
            wave_valid_q <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            sel_q        <= bus.Sel;
            acc_q        <= acc_d;
            win_cnt_q    <= win_cnt_d;
            wave_out_q   <= wave_out_d;
            wave_valid_q <= wave_valid_d;
            lost_q       <= lost_d;
        end
    end

    assign bus.wave_out     = wave_out_q;
    assign bus.wave_valid   = wave_valid_q;
    assign bus.carrier_lost = lost_q;

endmodule

// File: tb/tb_am_fm_demodulate.sv
// Directed scoreboard bench for am_fm_demodulate (W=12, mid=2048).
module tb_am_fm_demodulate;
    import demod_pkg::*;

    localparam int unsigned IW = 12;
    localparam int unsigned OW = 12;
    localparam int unsigned CW = 16;

    logic clk_in = 1'b0;
    logic RST;

    always #5 clk_in = ~clk_in;

    am_fm_demodulate_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .CNT_WIDTH(CW)) bus ();

    am_fm_demodulate #(
        .INPUT_WIDTH  (IW),
        .OUTPUT_WIDTH (OW),
        .CNT_WIDTH    (CW),
        .AVG_SHIFT    (4),
        .HYST         (64)
    ) dut (
        .clk_in (clk_in),
        .RST    (RST),
        .bus    (bus)
    );

    typedef struct {
        logic [OW-1:0] out;
        logic          lost;
        int unsigned   edge_n;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int unsigned edges = 0;
    int unsigned last_cross = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        edges++;
        #1;
    endtask

    task automatic strobe(input logic [IW-1:0] v);
        bus.sample_en = 1'b1;
        bus.wave_in   = v;
        tick();
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            bus.sample_en = 1'b0;
            bus.wave_in   = IW'($urandom_range(0, 4095));
            tick();
        end
    endtask

    // Expected output lands on the edge that samples the next strobe
    task automatic push_exp(input logic [OW-1:0] out, input logic lost, input int unsigned edge_n);
        exp_t e;
        e.out    = out;
        e.lost   = lost;
        e.edge_n = edge_n;
        sbq.push_back(e);
    endtask

    task automatic am_strobes(input int unsigned n, input logic [IW-1:0] a, input logic [IW-1:0] b,
                              input bit push, input logic [OW-1:0] expv);
        for (int unsigned i = 0; i < n; i++) begin
            if (push && i == n - 1) push_exp(expv, 1'b0, edges + 1);
            strobe((i % 2 == 0) ? a : b);
        end
    endtask

    task automatic am_windows(input int unsigned nwin, input logic [IW-1:0] a, input logic [IW-1:0] b,
                              input logic [OW-1:0] expv);
        for (int unsigned w = 0; w < nwin; w++) am_strobes(16, a, b, 1'b1, expv);
    endtask

    function automatic logic [OW-1:0] exp_fm(input int center, input int per, input int shift);
        longint v;
        v = 64'sd2048 + (longint'(center) - longint'(per)) * (longint'(1) << shift);
        if (v < 0)    return '0;
        if (v > 4095) return '1;
        return OW'(v);
    endfunction

    task automatic fm_restart(input int unsigned center, input int unsigned shift);
        bus.center_period = CW'(center);
        bus.fm_gain_shift = 4'(shift);
        bus.Sel = MODE_AM;
        strobe(12'd2048);
        bus.Sel = MODE_FM;
        strobe(12'd2048);
    endtask

    // Square wave: low half then high half; rising crossing on first high strobe
    task automatic fm_square(input int unsigned per, input int unsigned nper, input bit armed,
                             input logic [OW-1:0] expv);
        int unsigned lo_n;
        int unsigned hi_n;
        lo_n = per / 2;
        hi_n = per - lo_n;
        for (int unsigned p = 0; p < nper; p++) begin
            for (int unsigned i = 0; i < lo_n; i++) strobe(12'd1048);
            for (int unsigned i = 0; i < hi_n; i++) begin
                if (i == 0) begin
                    if (p > 0 || armed) push_exp(expv, 1'b0, edges + 1);
                    last_cross = edges + 1;
                end
                strobe(12'd3048);
            end
        end
    endtask

    // Scoreboard consumer, sampled on the falling edge
    always @(negedge clk_in) begin
        if (RST === 1'b1 && bus.wave_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("spurious_valid", 64'(sbq.size()), 64'd1);
            end else begin
                mon_e = sbq.pop_front();
                check("valid_edge", 64'(edges), 64'(mon_e.edge_n));
                check("wave_out", 64'(bus.wave_out), 64'(mon_e.out));
                check("carrier_lost", 64'(bus.carrier_lost), 64'(mon_e.lost));
            end
        end
    end

    initial begin
        int unsigned t_edge;
        RST               = 1'b0;
        bus.Sel           = MODE_AM;
        bus.sample_en     = 1'b0;
        bus.wave_in       = 12'd2048;
        bus.center_period = CW'(20);
        bus.fm_gain_shift = 4'd4;
        repeat (3) tick();
        check("reset_wave_out", 64'(bus.wave_out), 64'd2048);
        check("reset_wave_valid", 64'(bus.wave_valid), 64'd0);
        check("reset_carrier_lost", 64'(bus.carrier_lost), 64'd0);
        RST = 1'b1;

        // AM envelope, three back-to-back windows
        am_windows(3, 12'd2548, 12'd1548, 12'd1000);
        check("am_lost_low", 64'(bus.carrier_lost), 64'd0);
        // Full-scale extremes (offset 0 saturates) and a flat midscale input
        am_windows(1, 12'd0, 12'd4095, 12'd4094);
        am_windows(1, 12'd2048, 12'd2048, 12'd0);
        // Strobe gaps pause the window
        am_strobes(8, 12'd2548, 12'd1548, 1'b0, '0);
        idle(5);
        am_strobes(8, 12'd2548, 12'd1548, 1'b1, 12'd1000);

        // Mode switch mid-window discards the partial window
        am_strobes(7, 12'd2548, 12'd1548, 1'b0, '0);
        bus.Sel = MODE_FM;
        strobe(12'd2048);
        check("switch_hold_out", 64'(bus.wave_out), 64'd1000);
        check("switch_no_valid", 64'(bus.wave_valid), 64'd0);
        strobe(12'd2048);
        strobe(12'd2048);
        bus.Sel = MODE_AM;
        strobe(12'd2548);
        check("return_no_valid", 64'(bus.wave_valid), 64'd0);
        am_windows(1, 12'd2548, 12'd1548, 12'd1000);

        // FM nominal and off-nominal periods
        fm_restart(20, 4);
        fm_square(20, 4, 1'b0, exp_fm(20, 20, 4));
        fm_restart(20, 4);
        fm_square(16, 3, 1'b0, exp_fm(20, 16, 4));
        // FM clamp at both rails
        fm_restart(1000, 8);
        fm_square(2, 4, 1'b0, exp_fm(1000, 2, 8));
        fm_restart(20, 4);
        fm_square(4000, 2, 1'b0, exp_fm(20, 4000, 4));

        // Carrier timeout: counter saturates 65535 strobes after the last crossing
        fm_restart(20, 4);
        fm_square(20, 2, 1'b0, exp_fm(20, 20, 4));
        t_edge = last_cross + 65535;
        push_exp(12'd2048, 1'b1, t_edge);
        while (edges < t_edge + 4) strobe(12'd2048);
        check("timeout_lost_set", 64'(bus.carrier_lost), 64'd1);
        check("timeout_out_mid", 64'(bus.wave_out), 64'd2048);
        check("timeout_drained", 64'(sbq.size()), 64'd0);
        // Recovery: first crossing only re-arms, second clears the flag
        fm_square(20, 1, 1'b0, '0);
        check("lost_after_first_cross", 64'(bus.carrier_lost), 64'd1);
        fm_square(20, 2, 1'b1, exp_fm(20, 20, 4));
        check("lost_after_recovery", 64'(bus.carrier_lost), 64'd0);

        idle(4);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
